dct_mac_ctrl: RTL and testbench

Sequencer for the DCT multiply-accumulate path: issues term indices to the multiplier and coefficient ROM, and drives the 28-bit accumulator controls (en, sub, new1) delayed to match multiplier latency.
Runs NOUT output rows of K terms each, back-to-back with no bubbles between rows, and flags each completed row sum.
Sits between the transform top-level FSM (start/done) and the muldct/accumulator datapath.

---
 rtl/dct_mac_ctrl.sv | 151 +++++++++++++++
 tb/tb_dct_mac_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dct_mac_ctrl.sv
// Term sequencer for the DCT multiply-accumulate path: issues K terms per row for NOUT rows
// and drives the accumulator controls delayed by MUL_LAT. Optional abort port: DCT_MAC_CTRL_ABORT_EN.
module dct_mac_ctrl #(
    parameter int K       = 23,
    parameter int NOUT    = 8,
    parameter int MUL_LAT = 2,
    parameter int IDXW    = 5,
    parameter int ROWW    = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    input  logic            term_sign,
`ifdef DCT_MAC_CTRL_ABORT_EN
    input  logic            abort,
`endif
    output logic            term_vld,
    output logic [IDXW-1:0] term_idx,
    output logic [ROWW-1:0] row_idx,
    output logic            acc_en,
    output logic            acc_sub,
    output logic            acc_new1,
    output logic            sum_vld,
    output logic [ROWW-1:0] sum_row,
    output logic            busy,
    output logic            done
);

    localparam logic [IDXW-1:0] K_LAST   = IDXW'(K - 1);
    localparam logic [ROWW-1:0] ROW_LAST = ROWW'(NOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDXW-1:0]   term_cnt;
    logic [ROWW-1:0]   row_cnt;
    logic              kill;
    logic              last_term;
    logic              last_row;

    logic [MUL_LAT-1:0] p_vld;
    logic [MUL_LAT-1:0] p_sub;
    logic [MUL_LAT-1:0] p_new;
    logic [MUL_LAT-1:0] p_last;
    logic [ROWW-1:0]    p_row [MUL_LAT];
    logic               sum_vld_q;
    logic [ROWW-1:0]    sum_row_q;

`ifdef DCT_MAC_CTRL_ABORT_EN
    assign kill = abort && (state != IDLE);
`else
    assign kill = 1'b0;
`endif

    assign last_term = (term_cnt == K_LAST);
    assign last_row  = (row_cnt == ROW_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        term_vld  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                term_vld = !stall;
                if (term_vld && last_term && last_row) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                // The final row sum is the only sum that can appear once issue has ended.
                done = sum_vld && (sum_row == ROW_LAST);
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (kill) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || kill || state == IDLE) begin
            term_cnt <= '0;
            row_cnt  <= '0;
        end else if (term_vld) begin
            if (last_term) begin
                term_cnt <= '0;
                row_cnt  <= row_cnt + ROWW'(1);
            end else begin
                term_cnt <= term_cnt + IDXW'(1);
            end
        end
    end

    // The delay line shifts every cycle, so a stall turns into an en=0 bubble downstream.
    always_ff @(posedge clk) begin
        if (reset || kill) begin
            p_vld     <= '0;
            p_sub     <= '0;
            p_new     <= '0;
            p_last    <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                p_row[i] <= '0;
            end
            sum_vld_q <= 1'b0;
            sum_row_q <= '0;
        end else begin
            p_vld[0]  <= term_vld;
            p_sub[0]  <= term_vld && term_sign;
            p_new[0]  <= term_vld && (term_cnt == '0);
            p_last[0] <= term_vld && last_term;
            p_row[0]  <= row_cnt;
            for (int i = 1; i < MUL_LAT; i++) begin
                p_vld[i]  <= p_vld[i-1];
                p_sub[i]  <= p_sub[i-1];
                p_new[i]  <= p_new[i-1];
                p_last[i] <= p_last[i-1];
                p_row[i]  <= p_row[i-1];
            end
            sum_vld_q <= p_vld[MUL_LAT-1] && p_last[MUL_LAT-1];
            sum_row_q <= p_row[MUL_LAT-1];
        end
    end

    assign acc_en   = p_vld[MUL_LAT-1];
    assign acc_sub  = p_vld[MUL_LAT-1] && p_sub[MUL_LAT-1];
    assign acc_new1 = p_vld[MUL_LAT-1] && p_new[MUL_LAT-1];
    assign sum_vld  = sum_vld_q && !kill;
    assign sum_row  = sum_vld_q ? sum_row_q : '0;
    assign busy     = (state != IDLE);
    assign term_idx = (state == ISSUE) ? term_cnt : '0;
    assign row_idx  = (state == ISSUE) ? row_cnt : '0;

endmodule

// File: tb/tb_dct_mac_ctrl.sv
// Scoreboard bench for dct_mac_ctrl: the driver pushes expected term/acc/sum events,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_dct_mac_ctrl;
    localparam int K       = 23;
    localparam int NOUT    = 8;
    localparam int MUL_LAT = 2;
    localparam int IDXW    = 5;
    localparam int ROWW    = 3;

    logic            clk;
    logic            reset;
    logic            start;
    logic            stall;
    logic            term_sign;
`ifdef DCT_MAC_CTRL_ABORT_EN
    logic            abort;
`endif
    logic            term_vld;
    logic [IDXW-1:0] term_idx;
    logic [ROWW-1:0] row_idx;
    logic            acc_en;
    logic            acc_sub;
    logic            acc_new1;
    logic            sum_vld;
    logic [ROWW-1:0] sum_row;
    logic            busy;
    logic            done;

    dct_mac_ctrl #(.K(K), .NOUT(NOUT), .MUL_LAT(MUL_LAT), .IDXW(IDXW), .ROWW(ROWW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stall(stall),
        .term_sign(term_sign),
`ifdef DCT_MAC_CTRL_ABORT_EN
        .abort(abort),
`endif
        .term_vld(term_vld),
        .term_idx(term_idx),
        .row_idx(row_idx),
        .acc_en(acc_en),
        .acc_sub(acc_sub),
        .acc_new1(acc_new1),
        .sum_vld(sum_vld),
        .sum_row(sum_row),
        .busy(busy),
        .done(done)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0]  term_q[$];
    logic [33:0] acc_q[$];
    logic [35:0] sum_q[$];

    int acc_model = 0;
    int row_sum[NOUT];
    int done_cnt = 0;
    int done_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: sum is read before this cycle's accumulator update (new1 may coincide)
    logic [35:0] m_sum;
    logic [33:0] m_acc;
    logic [7:0]  m_term;
    always @(negedge clk) begin
        if (sum_vld) begin
            if (sum_q.size() == 0) begin
                check("sum_unexpected", {sum_row, done}, 0);
            end else begin
                m_sum = sum_q.pop_front();
                check("sum_evt", {32'(cyc), sum_row, done}, m_sum);
            end
            row_sum[sum_row] = acc_model;
        end
        if (done) begin
            check("done_needs_sum", sum_vld, 1);
            done_cnt++;
            done_cyc = cyc;
        end
        if (acc_en) begin
            if (acc_q.size() == 0) begin
                check("acc_unexpected", {acc_sub, acc_new1}, 3'b100);
            end else begin
                m_acc = acc_q.pop_front();
                check("acc_evt", {32'(cyc), acc_sub, acc_new1}, m_acc);
            end
            if (acc_new1) acc_model = 5;
            else if (acc_sub) acc_model = acc_model - 5;
            else acc_model = acc_model + 5;
        end else begin
            check("acc_idle_ctrl", {acc_sub, acc_new1}, 0);
        end
        if (term_vld) begin
            if (term_q.size() == 0) begin
                check("term_unexpected", {row_idx, term_idx}, 9'h100);
            end else begin
                m_term = term_q.pop_front();
                check("term_evt", {row_idx, term_idx}, m_term);
            end
        end
    end

    // driver task: kill_kind 1 = reset, 2 = abort, at rel cycle kill_rel
    task automatic run_job(input int stall_row, input int stall_idx, input int stall_len,
                           input int restart_rel, input int kill_rel, input int kill_kind,
                           input int exp_done);
        int t0, r, i, left, rel, d0, missed;
        bit stalled, fin, killed;
        logic [31:0] cv;
        logic [ROWW-1:0] rr;
        logic [IDXW-1:0] ii;
        logic sg;
        r = 0; i = 0; left = 0; stalled = 0; fin = 0; killed = 0; missed = 0;
        for (int j = 0; j < NOUT; j++) row_sum[j] = -1;
        d0 = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t0 = cyc;
        check("busy_first_issue", busy, 1);
        while (!fin) begin
            rel = cyc - t0;
            start = (rel == restart_rel);
            if (!stalled && r == stall_row && i == stall_idx && stall_len > 0) begin
                stalled = 1;
                left = stall_len;
            end
            stall = (left > 0);
            if (left > 0) left--;
            sg = (i % 2 == 0);
            term_sign = sg;
            if (!stall) begin
                rr = ROWW'(r);
                ii = IDXW'(i);
                term_q.push_back({3'b0, rr, ii});
                cv = 32'(cyc + MUL_LAT);
                acc_q.push_back({cv, sg, i == 0});
                if (i == K - 1) begin
                    cv = 32'(cyc + MUL_LAT + 1);
                    sum_q.push_back({cv, rr, r == NOUT - 1});
                    i = 0;
                    r++;
                    if (r == NOUT) fin = 1;
                end else begin
                    i++;
                end
            end
            if (rel == kill_rel) begin
                if (kill_kind == 1) reset = 1'b1;
`ifdef DCT_MAC_CTRL_ABORT_EN
                if (kill_kind == 2) abort = 1'b1;
`endif
                killed = 1;
                fin = 1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; stall = 1'b0; reset = 1'b0; term_sign = 1'b0;
`ifdef DCT_MAC_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        if (killed) begin
            foreach (acc_q[j]) if (acc_q[j][33:2] <= 32'(t0 + kill_rel)) missed++;
            foreach (sum_q[j]) if (sum_q[j][35:4] <= 32'(t0 + kill_rel)) missed++;
            check("kill_missed_events", missed, 0);
            acc_q.delete(); sum_q.delete(); term_q.delete();
            check("kill_outputs_zero", {busy, term_vld, acc_en, acc_sub, acc_new1, sum_vld, done,
                                        term_idx, row_idx, sum_row}, 0);
            repeat (6) @(posedge clk);
            #1;
            check("kill_no_done", done_cnt - d0, 0);
            check("kill_busy", busy, 0);
        end else begin
            for (int k = 0; k < 20 && done_cnt == d0; k++) @(posedge clk);
            #1;
            check("done_seen", done_cnt != d0, 1);
            check("done_count", done_cnt - d0, 1);
            check("done_cycle", done_cyc - t0, exp_done);
            check("busy_after_done", busy, 0);
            check("queues_drained", {term_q.size() == 0, acc_q.size() == 0, sum_q.size() == 0}, 3'b111);
            check("row0_sum", row_sum[0], 5);
            check("row_last_sum", row_sum[NOUT-1], 5);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; term_sign = 1'b0;
`ifdef DCT_MAC_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {busy, term_vld, acc_en, acc_sub, acc_new1, sum_vld, done,
                                term_idx, row_idx, sum_row}, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_without_start", {busy, term_vld, acc_en}, 0);

        run_job(-1, -1, 0, -1, -1, 0, 186);   // plain job
        run_job(2, 10, 3, -1, -1, 0, 189);    // 3-cycle stall at row 2 term 10
        run_job(-1, -1, 0, 50, -1, 0, 186);   // start while busy is ignored
        run_job(-1, -1, 0, -1, 100, 1, 0);    // reset mid-job
        run_job(-1, -1, 0, -1, -1, 0, 186);   // replay after reset
`ifdef DCT_MAC_CTRL_ABORT_EN
        run_job(-1, -1, 0, -1, 60, 2, 0);     // abort mid-job
        run_job(-1, -1, 0, -1, -1, 0, 186);
`endif
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
